// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin front end that shares one combinational
// 32x32 signed Booth multiplier among NREQ requesters. It holds the operands
// for MUL_CYCLES clocks (multicycle path), then registers the product.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is a one-hot grant)
//   req_in1/req_in2   packed 32-bit operands, requester i at [32*i +: 32]
//   mul_in1/mul_in2   registered operands driven to the multiplier
//   mul_out           product from the multiplier
//   mul_overflow      overflow flag from the multiplier
//   resp_*            tagged response port (valid/ready, id, product, overflow)
//   op_count          completed-response count, saturating; only present
//                     when BOOTH_ARB_STATS_EN is defined
module booth_mul_arbiter #(
  parameter  int unsigned NREQ       = 4,
  parameter  int unsigned MUL_CYCLES = 2,
  localparam int unsigned IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [32*NREQ-1:0] req_in1,
  input  logic [32*NREQ-1:0] req_in2,
  output logic [31:0]        mul_in1,
  output logic [31:0]        mul_in2,
  input  logic [63:0]        mul_out,
  input  logic               mul_overflow,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDW-1:0]     resp_id,
  output logic [63:0]        resp_out,
  output logic               resp_overflow
`ifdef BOOTH_ARB_STATS_EN
  ,
  output logic [15:0]        op_count
`endif
);

  localparam int unsigned CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state_q;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  cnt_q;
  logic [IDW-1:0] id_q;
  logic [31:0]    mul_in1_q, mul_in2_q;
  logic           resp_valid_q;
  logic [IDW-1:0] resp_id_q;
  logic [63:0]    resp_out_q;
  logic           resp_overflow_q;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  int unsigned    scan;

  logic [31:0]    in1_arr [NREQ];
  logic [31:0]    in2_arr [NREQ];

  // Unpack the flat operand buses into per-requester words.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign in1_arr[i] = req_in1[32*i +: 32];
    assign in2_arr[i] = req_in2[32*i +: 32];
  end

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan = 32'(rr_ptr_q) + k;
      if (scan >= NREQ) scan = scan - NREQ;
      if (!grant_found && req_valid[IDW'(scan)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(scan);
      end
    end
  end

  // Pointer moves just past the winner so it cannot win twice in a row under contention.
  assign rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // Grant is combinational so a requester sees its accept in the same cycle.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && grant_found) begin
      req_ready = NREQ'(1) << grant_idx;
    end
  end

  // Control FSM and all registered datapath state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      cnt_q           <= '0;
      id_q            <= '0;
      mul_in1_q       <= '0;
      mul_in2_q       <= '0;
      resp_valid_q    <= 1'b0;
      resp_id_q       <= '0;
      resp_out_q      <= '0;
      resp_overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_found) begin
            mul_in1_q <= in1_arr[grant_idx];
            mul_in2_q <= in2_arr[grant_idx];
            id_q      <= grant_idx;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= CW'(MUL_CYCLES - 1);
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          // Operands have been stable MUL_CYCLES clocks when cnt reaches zero.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            resp_out_q      <= mul_out;
            resp_overflow_q <= mul_overflow;
            resp_id_q       <= id_q;
            resp_valid_q    <= 1'b1;
            state_q         <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_in1       = mul_in1_q;
  assign mul_in2       = mul_in2_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_out      = resp_out_q;
  assign resp_overflow = resp_overflow_q;

`ifdef BOOTH_ARB_STATS_EN
  logic [15:0] op_count_q;

  // Completed-response counter, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (resp_valid_q && resp_ready && op_count_q != 16'hFFFF) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Shares one combinational 32x32 signed Booth multiplier instance among NREQ requesters.
- Round-robin arbitration with valid/ready handshakes on each request port and on a single tagged response port.
- Holds the multiplier operands stable for MUL_CYCLES clocks (multicycle path), then registers the 64-bit product and the overflow flag.
- Sits between the ALU/DSP clients and the multiplier instance; owns the only path into it.

Parameters:
- NREQ, 4, number of requesters (>=1).
- MUL_CYCLES, 2, clocks the operands are held before the product is captured (>=1; must cover multiplier combinational delay).
- IDW (localparam), NREQ>1 ? $clog2(NREQ) : 1, requester ID width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  one-hot grant/accept; at most one bit high.
- req_in1  input  32*NREQ  multiplicands, requester i at [32*i+31:32*i], two's complement.
- req_in2  input  32*NREQ  multipliers, same packing.
- mul_in1  output  32  operand to multiplier in1 (registered).
- mul_in2  output  32  operand to multiplier in2 (registered).
- mul_out  input  64  product from multiplier.
- mul_overflow  input  1  overflow flag from multiplier.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumer ready.
- resp_id  output  IDW  index of the requester that owns the response.
- resp_out  output  64  signed product.
- resp_overflow  output  1  captured overflow flag.

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE, rr_ptr=0, cnt=0, grant ID=0.
  - mul_in1=mul_in2=0, resp_valid=0, resp_out=0, resp_id=0, resp_overflow=0.
  - req_ready is forced 0 while rst is high.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - req_ready is combinational. The bit is high for g, the first index with req_valid set, searching cyclically from rr_ptr upward. All bits are 0 if no req_valid.
  - On an edge with any req_valid: latch req_in1[g] and req_in2[g] into mul_in1/mul_in2, latch g as the ID, set rr_ptr=(g+1) mod NREQ, set cnt=MUL_CYCLES-1, go to BUSY.
- BUSY:
  - req_ready=0 and the operands are held.
  - If cnt!=0: cnt decrements.
  - If cnt==0: capture mul_out into resp_out, mul_overflow into resp_overflow and the ID into resp_id; set resp_valid=1; go to RESP.
  - Latency: resp_valid rises MUL_CYCLES edges after the accept edge.
- RESP:
  - req_ready=0; all resp_* outputs are held stable.
  - On an edge with resp_ready=1: resp_valid=0, go to IDLE. resp_out and resp_id keep their values.
  - No accept happens in the same cycle as the response handshake.
  - Minimum issue interval is MUL_CYCLES+2 cycles.
- Operand hold: mul_in1/mul_in2 keep their last values in IDLE and RESP.
- Requester rules: a requester holds req_valid and its operands until its req_ready bit is seen. If req_valid drops before grant, no accept occurs for that requester.
- Simultaneous requests: only one is granted per accept. The others keep waiting, and rr_ptr guarantees each waits at most NREQ-1 grants.
- resp_ready held high continuously: each response completes one cycle after resp_valid rises.
- Reset mid-operation (BUSY or RESP): the operation is abandoned with no response, and all state returns to its reset values.
- NREQ=1: rr_ptr stays 0 and resp_id is always 0.
- Arithmetic: no width changes. The product and overflow are passed through exactly as produced by the multiplier.

Optional Feature:
- Macro BOOTH_ARB_STATS_EN adds output op_count (16 bits).
- op_count resets to 0 and increments on each response handshake (resp_valid & resp_ready), saturating at 16'hFFFF.
- Without the macro, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- Req1 only, in1=6, in2=7, resp_ready=1, MUL_CYCLES=2 -> accepted; resp_valid 2 edges later; resp_out=64'd42, resp_id=1, resp_overflow equal to mul_overflow.
- Req0, in1=-3 (32'hFFFFFFFD), in2=5 -> resp_out=64'hFFFFFFFFFFFFFFF1, resp_id=0.
- All four req_valid high from reset, each with in1=i+1 and in2=10 -> grants in order 0,1,2,3; products 10,20,30,40; then the next grant returns to 0.
- Req0 held valid continuously, req2 valid continuously -> grant sequence alternates 0,2,0,2; req0 never granted twice in a row.
- resp_ready low for 5 cycles after resp_valid -> resp_out, resp_id and resp_valid hold; req_ready stays 0; the response completes on the first edge with resp_ready=1.
- rst asserted for 1 cycle while in BUSY -> no resp_valid; rr_ptr=0; with BOOTH_ARB_STATS_EN, op_count=0 and it reads 3 after three completed responses.
